// File: rtl/crc_corr_pkg.sv
// Shared types and defaults for the CRC burst-error corrector.
package crc_corr_pkg;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'b00,
        ST_SINGLE = 2'b01,
        ST_BURST  = 2'b10,
        ST_UNCORR = 2'b11
    } corr_status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SEARCH = 2'b01,
        S_DONE   = 2'b10
    } fsm_state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One Galois LFSR step: s_out = x * s_in mod G(x), G given without its x^CRC_W term.
module crc_lfsr_step #(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(16'h1021)
) (
    input  logic [CRC_W-1:0] s_in,
    output logic [CRC_W-1:0] s_out
);

    assign s_out = {s_in[CRC_W-2:0], 1'b0} ^ (s_in[CRC_W-1] ? POLY : '0);

endmodule

// File: rtl/crc_burst_corrector.sv
// Serial CRC error locator: steps x^pos mod G across the codeword and flips the
// single bit or adjacent bit pair whose syndrome matches the one supplied.
module crc_burst_corrector
    import crc_corr_pkg::*;
#(
    parameter int               DATA_W   = 16,
    parameter int               CRC_W    = 16,
    parameter logic [CRC_W-1:0] POLY     = CRC_W'(DEFAULT_POLY),
    parameter int               BURST_HW = 1,
    parameter int               CNT_W    = 16,
    localparam int              CW_W     = DATA_W + CRC_W,
    localparam int              POS_W    = $clog2(CW_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_cw,
    input  logic [CRC_W-1:0]  in_syn,
    input  logic              burst_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
    output logic [POS_W-1:0]  out_pos,
    output logic              busy,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    // Both ports are valid/ready: a transfer occurs on a rising edge where valid and
    // ready are both high; the sender holds valid and payload stable until that edge.

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(CW_W - 1);

    fsm_state_e         state_q, state_d;
    logic [CW_W-1:0]    cw_q, cw_d;
    logic [CRC_W-1:0]   syn_q, syn_d;
    logic [CRC_W-1:0]   s_cur_q, s_cur_d;
    logic [CRC_W-1:0]   s_nxt;
    logic               burst_q, burst_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    corr_status_e       status_q, status_d;
    logic [CNT_W-1:0]   cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]   cnt_uncorr_q, cnt_uncorr_d;

    logic single_hit;
    logic burst_hit;
    logic last_pos;
    logic corr_inc;
    logic uncorr_inc;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .s_in  (s_cur_q),
        .s_out (s_nxt)
    );

    // A pair at pos has syndrome x^pos + x^(pos+1), i.e. s_cur ^ s_nxt.
    assign single_hit = (syn_q == s_cur_q);
    assign burst_hit  = burst_q && (pos_q != POS_LAST) && (syn_q == (s_cur_q ^ s_nxt));
    assign last_pos   = (pos_q == POS_LAST);
    assign corr_inc   = (state_q == S_SEARCH) && (single_hit || burst_hit);
    assign uncorr_inc = (state_q == S_SEARCH) && !single_hit && !burst_hit && last_pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = (in_syn == '0) ? S_DONE : S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (single_hit || burst_hit || last_pos) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_SEARCH) || (state_q == S_DONE);
    end

    always_comb begin
        cw_d     = cw_q;
        syn_d    = syn_q;
        s_cur_d  = s_cur_q;
        burst_d  = burst_q;
        pos_d    = pos_q;
        status_d = status_q;
        if (state_q == S_IDLE && in_valid) begin
            cw_d     = in_cw;
            syn_d    = in_syn;
            s_cur_d  = CRC_W'(1);
            burst_d  = (BURST_HW != 0) ? burst_en : 1'b0;
            pos_d    = '0;
            status_d = ST_CLEAN;
        end else if (state_q == S_SEARCH) begin
            if (single_hit) begin
                cw_d     = cw_q ^ (CW_W'(1) << pos_q);
                status_d = ST_SINGLE;
            end else if (burst_hit) begin
                cw_d     = cw_q ^ (CW_W'(3) << pos_q);
                status_d = ST_BURST;
            end else if (last_pos) begin
                pos_d    = '0;
                status_d = ST_UNCORR;
            end else begin
                pos_d    = pos_q + POS_W'(1);
                s_cur_d  = s_nxt;
            end
        end
    end

    // Clear wins over a coincident increment; counts stick at all-ones.
    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (stat_clr) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else begin
            if (corr_inc && (cnt_corr_q != '1)) begin
                cnt_corr_d = cnt_corr_q + CNT_W'(1);
            end
            if (uncorr_inc && (cnt_uncorr_q != '1)) begin
                cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_q         <= '0;
            syn_q        <= '0;
            s_cur_q      <= '0;
            burst_q      <= 1'b0;
            pos_q        <= '0;
            status_q     <= ST_CLEAN;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            cw_q         <= cw_d;
            syn_q        <= syn_d;
            s_cur_q      <= s_cur_d;
            burst_q      <= burst_d;
            pos_q        <= pos_d;
            status_q     <= status_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign out_data   = cw_q[CW_W-1:CRC_W];
    assign out_status = status_q;
    assign out_pos    = pos_q;
    assign cnt_corr   = cnt_corr_q;
    assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_crc_burst_corrector.sv
// Randomised and directed bench for crc_burst_corrector against a polynomial-division model.
module tb_crc_burst_corrector;

    localparam int DATA_W = 16;
    localparam int CRC_W  = 16;
    localparam int CW_W   = 32;
    localparam int POS_W  = 5;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CRC_W-1:0] POLY = 16'h1021;
    localparam int EXP_W = 8 + POS_W + 2 + DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CW_W-1:0]   in_cw = '0;
    logic [CRC_W-1:0]  in_syn = '0;
    logic              burst_en = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic [POS_W-1:0]  out_pos;
    logic              busy;
    logic              stat_clr = 1'b0;
    logic [CNT_W-1:0]  cnt_corr;
    logic [CNT_W-1:0]  cnt_uncorr;

    int n_checks = 0;
    int n_errors = 0;
    int exp_corr = 0;
    int exp_uncorr = 0;
    logic [EXP_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] cur_data;
    logic [1:0]        cur_status;
    logic [POS_W-1:0]  cur_pos;

    crc_burst_corrector #(
        .DATA_W   (DATA_W),
        .CRC_W    (CRC_W),
        .POLY     (POLY),
        .BURST_HW (1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cw      (in_cw),
        .in_syn     (in_syn),
        .burst_en   (burst_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_status (out_status),
        .out_pos    (out_pos),
        .busy       (busy),
        .stat_clr   (stat_clr),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [CRC_W-1:0] poly_rem(input logic [63:0] v);
        logic [63:0] r;
        logic [63:0] g;
        r = v;
        g = (64'd1 << CRC_W) | 64'(POLY);
        for (int i = 63; i >= CRC_W; i--) begin
            if (r[i]) r = r ^ (g << (i - CRC_W));
        end
        return r[CRC_W-1:0];
    endfunction

    task automatic predict(input logic [CW_W-1:0] cw, input logic [CRC_W-1:0] syn, input logic ben);
        logic [CW_W-1:0]  fixed;
        logic [1:0]       st;
        logic [POS_W-1:0] p;
        int               lat;
        fixed = cw;
        st    = 2'b11;
        p     = '0;
        lat   = CW_W + 1;
        if (syn == '0) begin
            st  = 2'b00;
            lat = 1;
        end else begin
            for (int k = 0; k < CW_W; k++) begin
                if (poly_rem(64'd1 << k) == syn) begin
                    fixed = cw ^ (CW_W'(1) << k);
                    st = 2'b01; p = POS_W'(k); lat = k + 2;
                    break;
                end
                if (ben && k < CW_W - 1 && poly_rem(64'd3 << k) == syn) begin
                    fixed = cw ^ (CW_W'(3) << k);
                    st = 2'b10; p = POS_W'(k); lat = k + 2;
                    break;
                end
            end
        end
        exp_q.push_back({8'(lat), p, st, fixed[CW_W-1:CRC_W]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_word(input logic [CW_W-1:0] cw, input logic [CRC_W-1:0] syn, input logic ben);
        int n;
        predict(cw, syn, ben);
        @(negedge clk);
        in_cw = cw; in_syn = syn; burst_en = ben; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_timeout", 32'(n < 100), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic [EXP_W-1:0] e;
        int lat;
        e = exp_q.pop_front();
        {cur_pos, cur_status, cur_data} = e[EXP_W-9:0];
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (cur_status == 2'b01 || cur_status == 2'b10) begin
            if (exp_corr < CNT_MAX) exp_corr++;
        end else if (cur_status == 2'b11) begin
            if (exp_uncorr < CNT_MAX) exp_uncorr++;
        end
        check_eq("latency", 32'(lat), 32'(e[EXP_W-1:EXP_W-8]));
        check_eq("out_data", 32'(out_data), 32'(cur_data));
        check_eq("out_status", 32'(out_status), 32'(cur_status));
        check_eq("out_pos", 32'(out_pos), 32'(cur_pos));
        check_eq("done_busy", 32'(busy), 32'd1);
        check_eq("done_in_ready", 32'(in_ready), 32'd0);
        check_eq("cnt_corr", 32'(cnt_corr), 32'(exp_corr));
        check_eq("cnt_uncorr", 32'(cnt_uncorr), 32'(exp_uncorr));
    endtask

    task automatic release_word(input int hold);
        repeat (hold) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_data", 32'(out_data), 32'(cur_data));
            check_eq("hold_status", 32'(out_status), 32'(cur_status));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_hs_valid", 32'(out_valid), 32'd0);
        check_eq("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic clr_stats();
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        exp_corr = 0;
        exp_uncorr = 0;
        check_eq("clr_corr", 32'(cnt_corr), 32'd0);
        check_eq("clr_uncorr", 32'(cnt_uncorr), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [CW_W-1:0]   cw;
        logic [DATA_W-1:0] d;
        int kind;

        #1 rst = 1'b1;
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_status", 32'(out_status), 32'd0);
        check_eq("rst_pos", 32'(out_pos), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cnt_corr", 32'(cnt_corr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // directed cases
        start_word(32'hABCD_1234, 16'h0000, 1'b0); wait_done(); release_word(0);
        start_word(32'h1234_5678, 16'h0001, 1'b0); wait_done(); release_word(0);
        start_word(32'h0001_0000, 16'h1021, 1'b0); wait_done(); release_word(0);
        check_eq("two_corrected", 32'(cnt_corr), 32'd2);
        start_word(32'h1234_5678, 16'h0003, 1'b1); wait_done(); release_word(0);
        start_word(32'h1234_5678, 16'h0003, 1'b0); wait_done(); release_word(0);
        start_word(32'h5A5A_0000, 16'h0015, 1'b0); wait_done(); release_word(1);

        // backpressure with a new word offered during DONE
        start_word(32'hC0DE_0000, 16'h0001, 1'b0);
        wait_done();
        predict(32'h1111_2222, 16'h0000, 1'b0);
        in_cw = 32'h1111_2222; in_syn = 16'h0000; burst_en = 1'b0; in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_data", 32'(out_data), 32'(cur_data));
            check_eq("bp_pos", 32'(out_pos), 32'(cur_pos));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("ovl_no_accept", 32'(out_valid), 32'd0);
        check_eq("ovl_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done();
        release_word(0);

        // asynchronous reset in the middle of a search
        start_word(32'h5A5A_0000, 16'h0015, 1'b0);
        repeat (5) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        void'(exp_q.pop_front());
        exp_corr = 0;
        exp_uncorr = 0;
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_data", 32'(out_data), 32'd0);
        check_eq("arst_cnt_corr", 32'(cnt_corr), 32'd0);
        check_eq("arst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // saturation, then clear coincident with an increment
        for (int i = 0; i < 5; i++) begin
            start_word(32'($urandom), 16'h0001, 1'($urandom_range(0, 1)));
            wait_done();
            release_word(0);
        end
        check_eq("sat_corr", 32'(cnt_corr), 32'd3);
        start_word(32'h0F0F_F0F0, 16'h0001, 1'b0);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        void'(exp_q.pop_front());
        exp_corr = 0;
        check_eq("clr_vs_inc_valid", 32'(out_valid), 32'd1);
        check_eq("clr_vs_inc_corr", 32'(cnt_corr), 32'd0);
        release_word(0);

        // randomised words: clean, single flip, adjacent pair, arbitrary
        for (int t = 0; t < 40; t++) begin
            d  = 16'($urandom);
            cw = {d, 16'h0000};
            cw[CRC_W-1:0] = poly_rem(64'(cw));
            kind = $urandom_range(0, 3);
            case (kind)
                1: cw = cw ^ (CW_W'(1) << $urandom_range(0, CW_W - 1));
                2: cw = cw ^ (CW_W'(3) << $urandom_range(0, CW_W - 2));
                3: cw = 32'($urandom);
                default: ;
            endcase
            start_word(cw, poly_rem(64'(cw)), 1'($urandom_range(0, 1)));
            wait_done();
            if ($urandom_range(0, 4) == 0) clr_stats();
            release_word($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
